// File: rtl/onchip_copier_pkg.sv
// Shared types and constants for the on-chip memory copier engine.
package onchip_copier_pkg;

    // Copier FSM states: one word moves through RD -> CAP -> WR.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } copier_state_t;

    // Depth of the target on-chip memory in words.
    localparam int MEM_WORDS = 32;

    // Full-word byte enable for the 32-bit target memory.
    localparam logic [3:0] BE_ALL = 4'hF;

endpackage : onchip_copier_pkg

// File: rtl/system_onchip_mem_copier.sv
// Avalon-MM master that copies a block of words inside a single-port
// on-chip memory. Each word is read (RD), captured (CAP) and written (WR),
// so one word is fully written before the next one is read.
// Optional feature: define ONCHIP_COPIER_CHECKSUM_EN to add a running
// 32-bit sum of every word read during the current command.
module system_onchip_mem_copier
    import onchip_copier_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [ADDR_W:0]       length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic                  clken,
    output logic                  reset_req,
    input  logic [DATA_W-1:0]     readdata
`ifdef ONCHIP_COPIER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]     checksum
`endif
);

    copier_state_t          state_q, state_d;
    logic [ADDR_W-1:0]      src_q, src_d;
    logic [ADDR_W-1:0]      dst_q, dst_d;
    logic [ADDR_W:0]        cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [ADDR_W-1:0]      address_q, address_d;
    logic                   chipselect_q, chipselect_d;
    logic                   write_q, write_d;
    logic [DATA_W-1:0]      data_q, data_d;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0]      checksum_q, checksum_d;
`endif

    // Next-state and next-output logic; memory-side outputs are computed for
    // the state being entered so they are registered and aligned with it.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        address_d    = address_q;
        data_d       = data_q;
        chipselect_d = 1'b0;
        write_d      = 1'b0;
        // The done pulse trails the DONE state by one register stage.
        done_d       = (state_q == S_DONE);
`ifdef ONCHIP_COPIER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is not accepted.
                if (start && !done_q) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    cnt_d = length;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_RD;
                        address_d    = src_addr;
                        chipselect_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                state_d      = S_WR;
                data_d       = readdata;
                address_d    = dst_q;
                chipselect_d = 1'b1;
                write_d      = 1'b1;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
                checksum_d   = checksum_q + readdata;
`endif
            end
            S_WR: begin
                // Addresses wrap naturally at the ADDR_W boundary.
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                cnt_d = cnt_q - (ADDR_W + 1)'(1);
                if (cnt_q == (ADDR_W + 1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d      = S_RD;
                    address_d    = src_q + ADDR_W'(1);
                    chipselect_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops chipselect/write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            address_q    <= '0;
            chipselect_q <= 1'b0;
            write_q      <= 1'b0;
            data_q       <= '0;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            address_q    <= address_d;
            chipselect_q <= chipselect_d;
            write_q      <= write_d;
            data_q       <= data_d;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign address    = address_q;
    assign chipselect = chipselect_q;
    assign write      = write_q;
    assign writedata  = data_q;
    assign byteenable = '1;
    assign clken      = 1'b1;
    assign reset_req  = 1'b0;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule : system_onchip_mem_copier
